// File: rtl/sha3_squeeze_if.sv
// sha3_squeeze_if: bundles the load, output-lane and re-permutation
// handshakes of the SHA3/SHAKE squeeze stage.
// The slave modport is the squeeze block; the master modport is its environment.
interface sha3_squeeze_if;
  logic          state_valid;
  logic          state_ready;
  logic [1599:0] state_in;
  logic [7:0]    out_lanes;
  logic          dout_valid;
  logic          dout_ready;
  logic [63:0]   dout;
  logic          dout_last;
  logic          perm_req;
  logic [1599:0] perm_state_out;
  logic          perm_ack;
  logic [1599:0] perm_state_in;

  modport slave (
    input  state_valid, state_in, out_lanes, dout_ready, perm_ack, perm_state_in,
    output state_ready, dout_valid, dout, dout_last, perm_req, perm_state_out
  );

  modport master (
    output state_valid, state_in, out_lanes, dout_ready, perm_ack, perm_state_in,
    input  state_ready, dout_valid, dout, dout_last, perm_req, perm_state_out
  );
endinterface

// File: rtl/sha3_squeeze.sv
// sha3_squeeze: streams 64-bit lanes out of a permuted 1600-bit Keccak state.
// When more lanes than the rate are requested, the state goes back to the
// permutation engine via perm_req/perm_ack and streaming resumes at lane 0.
// Optional macro SQUEEZE_BYTESWAP_EN: byte-reverse each output lane so that
// byte 0 of the lane appears in dout[63:56] (big-endian digest order).
// All outputs come straight from flops.
module sha3_squeeze #(
  parameter int RATE_LANES = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  sha3_squeeze_if.slave  bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EMIT      = 2'd1;
  localparam logic [1:0] S_PERM_WAIT = 2'd2;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  logic [1:0]    state_q, state_d;
  logic [1599:0] st_q, st_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [4:0]    lane_idx_q, lane_idx_d;
  logic [63:0]   dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;
  logic          state_ready_q, state_ready_d;
  logic          perm_req_q, perm_req_d;

  // Select lane k (k = 5y+x) of a state and apply the optional byte order.
  function automatic logic [63:0] pick_lane(input logic [1599:0] s, input logic [4:0] k);
    logic [63:0] lane;
    logic [63:0] swapped;
    lane = '0;
    for (int i = 0; i < 25; i++) begin
      if (k == 5'(i)) lane = s[64*i +: 64];
    end
    swapped = '0;
    for (int b = 0; b < 8; b++) begin
      swapped[8*(7-b) +: 8] = lane[8*b +: 8];
    end
`ifdef SQUEEZE_BYTESWAP_EN
    return swapped;
`else
    return lane;
`endif
  endfunction

  // Next-state logic: outputs are precomputed here so they can be registered.
  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    remaining_d   = remaining_q;
    lane_idx_d    = lane_idx_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    dout_last_d   = dout_last_q;
    state_ready_d = state_ready_q;
    perm_req_d    = perm_req_q;

    case (state_q)
      S_IDLE: begin
        if (bus.state_valid) begin
          st_d        = bus.state_in;
          remaining_d = bus.out_lanes;
          lane_idx_d  = '0;
          if (bus.out_lanes != 8'd0) begin
            state_d       = S_EMIT;
            dout_d        = pick_lane(bus.state_in, 5'd0);
            dout_valid_d  = 1'b1;
            dout_last_d   = (bus.out_lanes == 8'd1);
            state_ready_d = 1'b0;
          end
        end
      end

      S_EMIT: begin
        if (bus.dout_ready) begin
          remaining_d = remaining_q - 8'd1;
          lane_idx_d  = (lane_idx_q == LAST_IDX) ? 5'd0 : lane_idx_q + 5'd1;
          if (remaining_q == 8'd1) begin
            state_d       = S_IDLE;
            dout_valid_d  = 1'b0;
            dout_last_d   = 1'b0;
            state_ready_d = 1'b1;
          end else if (lane_idx_q == LAST_IDX) begin
            state_d      = S_PERM_WAIT;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            perm_req_d   = 1'b1;
          end else begin
            dout_d      = pick_lane(st_q, lane_idx_q + 5'd1);
            dout_last_d = (remaining_q == 8'd2);
          end
        end
      end

      S_PERM_WAIT: begin
        if (bus.perm_ack) begin
          st_d         = bus.perm_state_in;
          lane_idx_d   = '0;
          state_d      = S_EMIT;
          perm_req_d   = 1'b0;
          dout_valid_d = 1'b1;
          dout_d       = pick_lane(bus.perm_state_in, 5'd0);
          dout_last_d  = (remaining_q == 8'd1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      st_q          <= '0;
      remaining_q   <= '0;
      lane_idx_q    <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      dout_last_q   <= 1'b0;
      state_ready_q <= 1'b1;
      perm_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      st_q          <= st_d;
      remaining_q   <= remaining_d;
      lane_idx_q    <= lane_idx_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dout_last_q   <= dout_last_d;
      state_ready_q <= state_ready_d;
      perm_req_q    <= perm_req_d;
    end
  end

  assign bus.state_ready    = state_ready_q;
  assign bus.dout_valid     = dout_valid_q;
  assign bus.dout           = dout_q;
  assign bus.dout_last      = dout_last_q;
  assign bus.perm_req       = perm_req_q;
  assign bus.perm_state_out = st_q;

endmodule

// File: tb/tb_sha3_squeeze.sv
// tb_sha3_squeeze: randomized self-checking bench for sha3_squeeze.
// Expected lanes come from a reference model: output lane i of a request is
// lane (i mod RATE) of the i/RATE-th state in the chain loaded, permuted, ...
module tb_sha3_squeeze;

  localparam int RATE    = 17;
  localparam int MAX_CYC = 3000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sha3_squeeze_if bus ();

  sha3_squeeze #(.RATE_LANES(RATE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1599:0] perm_pool [16];
  logic [1599:0] cur_st;

  logic [63:0]   got_lanes [$];
  logic          got_last  [$];
  logic [1599:0] got_perm  [$];
  int            stab_err;
  int            tim_err;
  logic          timed_out;
  logic          load_ready;
  logic          first_valid;
  logic          end_ready;
  logic          end_valid;

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [63:0] lane_of(input logic [1599:0] s, input int k);
    return s[64*k +: 64];
  endfunction

  function automatic logic [63:0] present(input logic [63:0] l);
    logic [63:0] r;
`ifdef SQUEEZE_BYTESWAP_EN
    for (int b = 0; b < 8; b++) r[63-8*b -: 8] = l[8*b +: 8];
`else
    r = l;
`endif
    return r;
  endfunction

  function automatic logic [1599:0] block_state(input int b);
    return (b == 0) ? cur_st : perm_pool[b-1];
  endfunction

  function automatic logic [63:0] exp_lane(input int i);
    return present(lane_of(block_state(i / RATE), i % RATE));
  endfunction

  // Drive one request and record what the DUT produced; the calling test judges it.
  // stall_pct < 0 selects the fixed ready pattern 1,0,0,1,0,0,...
  task automatic squeeze(input logic [1599:0] st, input int n, input int stall_pct,
                         input int ack_delay);
    int   cycles, wait_cnt, nperm;
    logic stalled, held_last, exp_perm, exp_valid;
    logic [63:0] held;
    got_lanes.delete(); got_last.delete(); got_perm.delete();
    stab_err = 0; tim_err = 0; timed_out = 1'b0; cur_st = st;
    load_ready = bus.state_ready;
    bus.state_in = st; bus.out_lanes = 8'(n); bus.state_valid = 1'b1;
    @(posedge clk); #1;
    bus.state_valid = 1'b0;
    first_valid = bus.dout_valid;
    cycles = 0; wait_cnt = 0; nperm = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    exp_perm = 1'b0; exp_valid = 1'b0;
    while (got_lanes.size() < n && !timed_out) begin
      if (stalled && (!bus.dout_valid || bus.dout !== held || bus.dout_last !== held_last))
        stab_err++;
      if (exp_perm && !bus.perm_req) tim_err++;
      if (exp_valid && !bus.dout_valid) tim_err++;
      exp_perm = 1'b0; exp_valid = 1'b0;
      if (stall_pct < 0) bus.dout_ready = (cycles % 3 == 0);
      else bus.dout_ready = ($urandom_range(99) >= stall_pct);
      bus.perm_ack = 1'b0;
      if (bus.perm_req) begin
        if (wait_cnt == 0) got_perm.push_back(bus.perm_state_out);
        if (wait_cnt == ack_delay && nperm < 16) begin
          bus.perm_ack = 1'b1;
          bus.perm_state_in = perm_pool[nperm];
          exp_valid = 1'b1;
        end
        wait_cnt++;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        got_lanes.push_back(bus.dout);
        got_last.push_back(bus.dout_last);
        if (got_lanes.size() < n) begin
          if (got_lanes.size() % RATE == 0) exp_perm = 1'b1;
          else exp_valid = 1'b1;
        end
      end
      stalled = bus.dout_valid && !bus.dout_ready;
      held = bus.dout; held_last = bus.dout_last;
      @(posedge clk); #1;
      if (bus.perm_ack) begin nperm++; wait_cnt = 0; bus.perm_ack = 1'b0; end
      cycles++;
      if (cycles > MAX_CYC) timed_out = 1'b1;
    end
    bus.dout_ready = 1'b0; bus.perm_ack = 1'b0;
    end_ready = bus.state_ready; end_valid = bus.dout_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus.state_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_state_ready got %b want 1", bus.state_ready); end
    tests_run++; if (bus.dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dout_valid got %b want 0", bus.dout_valid); end
    tests_run++; if (bus.dout_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dout_last got %b want 0", bus.dout_last); end
    tests_run++; if (bus.perm_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_perm_req got %b want 0", bus.perm_req); end
    tests_run++; if (bus.dout !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_dout got %h want 0", bus.dout); end
    tests_run++; if (bus.perm_state_out !== 1600'h0) begin tests_failed++; $display("[TB] FAIL reset_perm_state_out not zero"); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sha3_digest();
    logic [1599:0] st;
    logic [63:0] golden [4];
    golden[0] = 64'h66d71ebff8c6ffa7; golden[1] = 64'h62d661a05647c151;
    golden[2] = 64'hfa493be44dff80f5; golden[3] = 64'h4a43f8804b0ad882;
    st = rand_state();
    for (int i = 0; i < 4; i++) st[64*i +: 64] = golden[i];
    squeeze(st, 4, 0, 0);
    tests_run++; if (load_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL digest_load_ready got %b want 1", load_ready); end
    tests_run++; if (first_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL digest_first_valid got %b want 1", first_valid); end
    tests_run++; if (got_lanes.size() != 4) begin tests_failed++; $display("[TB] FAIL digest_count got %0d want 4", got_lanes.size()); end
    for (int i = 0; i < got_lanes.size(); i++) begin
      tests_run++;
      if (got_lanes[i] !== present(golden[i])) begin tests_failed++; $display("[TB] FAIL digest_lane%0d got %h want %h", i, got_lanes[i], present(golden[i])); end
      tests_run++;
      if (got_last[i] !== (i == 3)) begin tests_failed++; $display("[TB] FAIL digest_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
    tests_run++; if (tim_err != 0) begin tests_failed++; $display("[TB] FAIL digest_throughput got %0d gaps want 0", tim_err); end
    tests_run++; if (end_ready !== 1'b1 || end_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL digest_idle got ready=%b valid=%b want 1/0", end_ready, end_valid); end
  endtask

  task automatic test_backpressure();
    squeeze(rand_state(), 3, -1, 0);
    tests_run++; if (got_lanes.size() != 3) begin tests_failed++; $display("[TB] FAIL bp_count got %0d want 3", got_lanes.size()); end
    for (int i = 0; i < got_lanes.size(); i++) begin
      tests_run++;
      if (got_lanes[i] !== exp_lane(i) || got_last[i] !== (i == 2)) begin tests_failed++; $display("[TB] FAIL bp_lane%0d got %h/%b want %h/%b", i, got_lanes[i], got_last[i], exp_lane(i), (i == 2)); end
    end
    tests_run++; if (stab_err != 0) begin tests_failed++; $display("[TB] FAIL bp_stable got %0d changes want 0", stab_err); end
    tests_run++; if (end_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_idle got %b want 1", end_ready); end
  endtask

  task automatic test_rate_crossing();
    squeeze(rand_state(), 20, 0, 3);
    tests_run++; if (timed_out) begin tests_failed++; $display("[TB] FAIL rate_timeout got %0d lanes want 20", got_lanes.size()); end
    tests_run++; if (got_lanes.size() != 20) begin tests_failed++; $display("[TB] FAIL rate_count got %0d want 20", got_lanes.size()); end
    for (int i = 0; i < got_lanes.size(); i++) begin
      tests_run++;
      if (got_lanes[i] !== exp_lane(i) || got_last[i] !== (i == 19)) begin tests_failed++; $display("[TB] FAIL rate_lane%0d got %h/%b want %h/%b", i, got_lanes[i], got_last[i], exp_lane(i), (i == 19)); end
    end
    tests_run++; if (got_perm.size() != 1) begin tests_failed++; $display("[TB] FAIL rate_perm_count got %0d want 1", got_perm.size()); end
    else begin
      tests_run++; if (got_perm[0] !== cur_st) begin tests_failed++; $display("[TB] FAIL rate_perm_state lane0 got %h want %h", lane_of(got_perm[0], 0), lane_of(cur_st, 0)); end
    end
    if (got_lanes.size() > 17) begin
      tests_run++; if (got_lanes[17] !== present(lane_of(perm_pool[0], 0))) begin tests_failed++; $display("[TB] FAIL rate_lane17 got %h want %h", got_lanes[17], present(lane_of(perm_pool[0], 0))); end
    end
    tests_run++; if (tim_err != 0) begin tests_failed++; $display("[TB] FAIL rate_timing got %0d errors want 0", tim_err); end
  endtask

  task automatic test_zero_request();
    int bad;
    squeeze(rand_state(), 0, 0, 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.dout_valid !== 1'b0 || bus.state_ready !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL zero_request got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_stream();
    cur_st = rand_state();
    bus.state_in = cur_st; bus.out_lanes = 8'd4; bus.state_valid = 1'b1;
    @(posedge clk); #1;
    bus.state_valid = 1'b0; bus.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.dout_valid !== 1'b0 || bus.perm_req !== 1'b0 || bus.state_ready !== 1'b1 || bus.dout_last !== 1'b0)
    begin tests_failed++; $display("[TB] FAIL midrst_outputs got v=%b p=%b r=%b l=%b want 0 0 1 0", bus.dout_valid, bus.perm_req, bus.state_ready, bus.dout_last); end
    rst_n = 1'b1; bus.dout_ready = 1'b0;
    @(posedge clk); #1;
    squeeze(rand_state(), 2, 0, 0);
    tests_run++; if (got_lanes.size() != 2) begin tests_failed++; $display("[TB] FAIL midrst_count got %0d want 2", got_lanes.size()); end
    else begin
      tests_run++; if (got_lanes[0] !== exp_lane(0)) begin tests_failed++; $display("[TB] FAIL midrst_restart got %h want %h", got_lanes[0], exp_lane(0)); end
    end
  endtask

  task automatic test_byteswap();
    logic [1599:0] st;
    logic [63:0] want;
    st = rand_state();
    st[63:0] = 64'h0123456789ABCDEF;
`ifdef SQUEEZE_BYTESWAP_EN
    want = 64'hEFCDAB8967452301;
`else
    want = 64'h0123456789ABCDEF;
`endif
    squeeze(st, 1, 0, 0);
    tests_run++; if (got_lanes.size() != 1) begin tests_failed++; $display("[TB] FAIL swap_count got %0d want 1", got_lanes.size()); end
    else begin
      tests_run++; if (got_lanes[0] !== want || got_last[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL swap_lane got %h/%b want %h/1", got_lanes[0], got_last[0], want); end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      squeeze(rand_state(), 5, 0, 0);
      tests_run++; if (load_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b%0d_load_ready got %b want 1", r, load_ready); end
      tests_run++; if (got_lanes.size() != 5) begin tests_failed++; $display("[TB] FAIL b2b%0d_count got %0d want 5", r, got_lanes.size()); end
      for (int i = 0; i < got_lanes.size(); i++) begin
        tests_run++;
        if (got_lanes[i] !== exp_lane(i)) begin tests_failed++; $display("[TB] FAIL b2b%0d_lane%0d got %h want %h", r, i, got_lanes[i], exp_lane(i)); end
      end
    end
  endtask

  task automatic test_random();
    int n, sp, ad, lane_bad;
    for (int it = 0; it < 6; it++) begin
      n  = $urandom_range(60, 1);
      sp = $urandom_range(50, 0);
      ad = $urandom_range(4, 0);
      squeeze(rand_state(), n, sp, ad);
      lane_bad = 0;
      for (int i = 0; i < got_lanes.size(); i++)
        if (got_lanes[i] !== exp_lane(i) || got_last[i] !== (i == n - 1)) lane_bad++;
      tests_run++; if (got_lanes.size() != n || lane_bad != 0) begin tests_failed++; $display("[TB] FAIL rand%0d_lanes n=%0d got %0d lanes %0d wrong want %0d lanes 0 wrong", it, n, got_lanes.size(), lane_bad, n); end
      tests_run++; if (got_perm.size() != (n - 1) / RATE) begin tests_failed++; $display("[TB] FAIL rand%0d_perms got %0d want %0d", it, got_perm.size(), (n - 1) / RATE); end
      tests_run++; if (stab_err != 0 || tim_err != 0) begin tests_failed++; $display("[TB] FAIL rand%0d_protocol got stab=%0d tim=%0d want 0 0", it, stab_err, tim_err); end
    end
  endtask

  task automatic test_max_request();
    int lane_bad, perm_bad;
    squeeze(rand_state(), 255, 0, 0);
    lane_bad = 0; perm_bad = 0;
    for (int i = 0; i < got_lanes.size(); i++)
      if (got_lanes[i] !== exp_lane(i) || got_last[i] !== (i == 254)) lane_bad++;
    for (int p = 0; p < got_perm.size(); p++)
      if (got_perm[p] !== block_state(p)) perm_bad++;
    tests_run++; if (got_lanes.size() != 255 || lane_bad != 0) begin tests_failed++; $display("[TB] FAIL max_lanes got %0d lanes %0d wrong want 255 lanes 0 wrong", got_lanes.size(), lane_bad); end
    tests_run++; if (got_perm.size() != 14 || perm_bad != 0) begin tests_failed++; $display("[TB] FAIL max_perms got %0d perms %0d wrong want 14 perms 0 wrong", got_perm.size(), perm_bad); end
    tests_run++; if (tim_err != 0) begin tests_failed++; $display("[TB] FAIL max_timing got %0d errors want 0", tim_err); end
  endtask

  initial begin
    bus.state_valid = 1'b0; bus.state_in = '0; bus.out_lanes = '0;
    bus.dout_ready = 1'b0; bus.perm_ack = 1'b0; bus.perm_state_in = '0;
    for (int i = 0; i < 16; i++) perm_pool[i] = rand_state();
    test_reset();
    test_sha3_digest();
    test_backpressure();
    test_rate_crossing();
    test_zero_request();
    test_reset_mid_stream();
    test_byteswap();
    test_back_to_back();
    test_random();
    test_max_request();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
